// File: rtl/intc.sv
// intc: memory-mapped interrupt controller in front of the CP0 interrupt input.
// Latches level/edge requests into pending bits, masks them, picks the
// lowest-index source and tracks one in-service interrupt via ack/EOI.
// Optional feature: define INTC_SYNC_EN to add a 2-flop input synchronizer.
module intc #(
  parameter int unsigned N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:2]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             int_ack,
  output logic             IRQ,
  output logic [2:0]       IntId
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e           state_q;
  logic             irq_q;
  logic [2:0]       isr_id_q;
  logic [N_SRC-1:0] mask_q, mode_q, pend_q, pend_d;
  logic [N_SRC-1:0] s_q, s_prev_q;
  logic [N_SRC-1:0] pm, edge_set, edge_clr, eoi_clr;
  logic [2:0]       reg_sel, cand;
  logic             valid, in_service, eoi_match;
  logic             wr_mask, wr_pend, wr_mode, wr_eoi;
  logic             unused_bits;

  assign reg_sel = Addr[4:2];
  assign wr_mask = WE && (reg_sel == 3'd0);
  assign wr_pend = WE && (reg_sel == 3'd1);
  assign wr_mode = WE && (reg_sel == 3'd2);
  assign wr_eoi  = WE && (reg_sel == 3'd4);

  // Block select is done by the bridge; upper address and data bits are don't-care.
  assign unused_bits = ^{Addr[31:5], Din[31:N_SRC]};

  assign pm         = pend_q & mask_q;
  assign valid      = |pm;
  assign in_service = (state_q == StService);
  assign eoi_match  = wr_eoi && (Din[2:0] == isr_id_q);

  // Lowest index wins: scan from the top so the last hit is the smallest index.
  always_comb begin
    cand = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pm[i]) cand = 3'(i);
    end
  end

  // One-hot clear for the source named by an EOI write.
  always_comb begin
    eoi_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      eoi_clr[i] = wr_eoi && (Din[2:0] == 3'(i));
    end
  end

  assign edge_set = s_q & ~s_prev_q;
  assign edge_clr = (wr_pend ? Din[N_SRC-1:0] : '0) | eoi_clr;
  // Edge bits: set beats clear. Level bits simply track the sampled input.
  assign pend_d   = (mode_q & (edge_set | (pend_q & ~edge_clr))) | (~mode_q & s_q);

`ifdef INTC_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer ahead of the sample register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      s_q      <= '0;
      s_prev_q <= '0;
    end else begin
      sync1_q  <= irq_in;
      sync2_q  <= sync1_q;
      s_q      <= sync2_q;
      s_prev_q <= s_q;
    end
  end
`else
  // Single sample register plus its delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q      <= '0;
      s_prev_q <= '0;
    end else begin
      s_q      <= irq_in;
      s_prev_q <= s_q;
    end
  end
`endif

  // Software-visible registers and pending bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      mode_q <= '0;
      pend_q <= '0;
    end else begin
      if (wr_mask) mask_q <= Din[N_SRC-1:0];
      if (wr_mode) mode_q <= Din[N_SRC-1:0];
      pend_q <= pend_d;
    end
  end

  // Request/service FSM with registered IRQ (high exactly in StReq).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      irq_q    <= 1'b0;
      isr_id_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid) begin
            state_q <= StReq;
            irq_q   <= 1'b1;
          end
        end
        StReq: begin
          if (!valid) begin
            state_q <= StIdle;
            irq_q   <= 1'b0;
          end else if (int_ack) begin
            state_q  <= StService;
            irq_q    <= 1'b0;
            isr_id_q <= cand;
          end
        end
        StService: begin
          if (eoi_match) state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign IRQ   = irq_q;
  assign IntId = in_service ? isr_id_q : cand;

  // Read mux reflects register state before any same-cycle write.
  always_comb begin
    Dout = '0;
    case (reg_sel)
      3'd0:    Dout = {{(32 - N_SRC){1'b0}}, mask_q};
      3'd1:    Dout = {{(32 - N_SRC){1'b0}}, pend_q};
      3'd2:    Dout = {{(32 - N_SRC){1'b0}}, mode_q};
      3'd3:    Dout = {in_service | valid, 28'd0, IntId};
      default: Dout = '0;
    endcase
  end

endmodule
